// File: rtl/toysram_scan_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : toysram_scan_ctl
//  Description : Scan-driven access controller for the toysram test site.
//                Shifts a command word in from the scan pads, issues one
//                r0/r1/w0 array access, captures read data back into the
//                chain and presents the chain MSB on scan_do.
//  Revision    : 1.0 - initial release
// ============================================================================
module toysram_scan_ctl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_enable,
    input  logic              scan_clk,
    input  logic              scan_di,
    output logic              scan_do,
    output logic              r0_enb,
    output logic [ADDR_W-1:0] r0_adr,
    input  logic [DATA_W-1:0] r0_dat,
    output logic              r1_enb,
    output logic [ADDR_W-1:0] r1_adr,
    input  logic [DATA_W-1:0] r1_dat,
    output logic              w0_enb,
    output logic [ADDR_W-1:0] w0_adr,
    output logic [DATA_W-1:0] w0_dat,
    output logic              busy,
    output logic              done
);

    localparam int SCAN_W = 3 + 3*ADDR_W + 2*DATA_W;

    // Chain field offsets, LSB upwards: dat_b, dat_a, r1_adr, r0_adr, w0_adr, cmd
    localparam int c_DB_LO  = 0;
    localparam int c_DA_LO  = DATA_W;
    localparam int c_R1_LO  = 2*DATA_W;
    localparam int c_R0_LO  = c_R1_LO + ADDR_W;
    localparam int c_W0_LO  = c_R0_LO + ADDR_W;
    localparam int c_CMD_LO = c_W0_LO + ADDR_W;

    // Last WAIT count value; WAIT is bypassed entirely when RD_LAT is 1
    localparam logic [1:0] c_WAIT_LAST = (RD_LAT >= 2) ? 2'(RD_LAT - 2) : 2'd0;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_SHIFT   = 3'd1;
    localparam logic [2:0] c_ISSUE   = 3'd2;
    localparam logic [2:0] c_WAIT    = 3'd3;
    localparam logic [2:0] c_CAPTURE = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [SCAN_W-1:0] r_sr;
    logic [1:0]        r_wait_cnt;
    logic              r_done;

    logic r_te_m, r_te_s;
    logic r_sc_m, r_sc_s, r_sc_d;
    logic r_di_m, r_di_s;

    logic       w_sc_edge;
    logic [2:0] w_cmd;

    assign w_sc_edge = r_sc_s & ~r_sc_d;
    assign w_cmd     = r_sr[c_CMD_LO +: 3];

    // Two-flop synchronisers for the pad inputs plus a third scan_clk flop for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_te_m <= 1'b0;
            r_te_s <= 1'b0;
            r_sc_m <= 1'b0;
            r_sc_s <= 1'b0;
            r_sc_d <= 1'b0;
            r_di_m <= 1'b0;
            r_di_s <= 1'b0;
        end else begin
            r_te_m <= test_enable;
            r_te_s <= r_te_m;
            r_sc_m <= scan_clk;
            r_sc_s <= r_sc_m;
            r_sc_d <= r_sc_s;
            r_di_m <= scan_di;
            r_di_s <= r_di_m;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a cleared cmd on exit from SHIFT returns straight to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (r_te_s) begin
                    w_state_nxt = c_SHIFT;
                end
            end
            c_SHIFT: begin
                if (!r_te_s) begin
                    w_state_nxt = (w_cmd != 3'b000) ? c_ISSUE : c_IDLE;
                end
            end
            c_ISSUE: begin
                w_state_nxt = (RD_LAT <= 1) ? c_CAPTURE : c_WAIT;
            end
            c_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt = c_CAPTURE;
                end
            end
            c_CAPTURE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Output decode: enables pulse only during ISSUE, busy covers ISSUE..CAPTURE
    always_comb begin
        r0_enb = 1'b0;
        r1_enb = 1'b0;
        w0_enb = 1'b0;
        busy   = 1'b0;
        if (r_state == c_ISSUE) begin
            r0_enb = w_cmd[2];
            r1_enb = w_cmd[1];
            w0_enb = w_cmd[0];
        end
        if ((r_state == c_ISSUE) || (r_state == c_WAIT) || (r_state == c_CAPTURE)) begin
            busy = 1'b1;
        end
    end

    // Read-latency counter, restarted on every ISSUE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 2'd0;
        end else if (r_state == c_ISSUE) begin
            r_wait_cnt <= 2'd0;
        end else if (r_state == c_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
        end
    end

    // Scan chain: serial shift in SHIFT, read-data capture and cmd clear in CAPTURE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if ((r_state == c_SHIFT) && w_sc_edge) begin
            r_sr <= {r_sr[SCAN_W-2:0], r_di_s};
        end else if (r_state == c_CAPTURE) begin
            if (w_cmd[2]) begin
                r_sr[c_DA_LO +: DATA_W] <= r0_dat;
            end
            if (w_cmd[1]) begin
                r_sr[c_DB_LO +: DATA_W] <= r1_dat;
            end
            r_sr[c_CMD_LO +: 3] <= 3'b000;
        end
    end

    // Completion pulse, raised the cycle after CAPTURE so it marks the finished update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == c_CAPTURE);
        end
    end

    assign done    = r_done;
    assign scan_do = r_sr[SCAN_W-1];
    assign w0_adr  = r_sr[c_W0_LO +: ADDR_W];
    assign r0_adr  = r_sr[c_R0_LO +: ADDR_W];
    assign r1_adr  = r_sr[c_R1_LO +: ADDR_W];
    assign w0_dat  = r_sr[c_DA_LO +: DATA_W];

endmodule
`default_nettype wire
